// File: rtl/i2c_reg_master.sv
// Open-drain I2C register master: one command in (START/addr/reg/data/STOP), one response out.
// Each SCL bit is four divider quarters; SCL stretching is honoured at the Q2->Q3 boundary.
module i2c_reg_master #(
    parameter int unsigned CLK_DIV = 250
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rw,
    input  logic [6:0]  cmd_dev,
    input  logic [7:0]  cmd_reg,
    input  logic [1:0]  cmd_len_m1,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_nack,
    output logic        busy,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        scl_oe,
    output logic        sda_oe
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR_W, S_REG, S_WDATA,
        S_RSTART, S_ADDR_R, S_RDATA, S_STOP, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     quarter_q, quarter_d;
    logic [DW-1:0]  div_q, div_d;
    logic [3:0]     bit_q, bit_d;
    logic [1:0]     byte_q, byte_d;
    logic [7:0]     sh_q, sh_d;
    logic [31:0]    rd_q, rd_d;
    logic           nack_q, nack_d;
    logic           rw_q, rw_d;
    logic [6:0]     dev_q, dev_d;
    logic [7:0]     reg_q, reg_d;
    logic [1:0]     len_q, len_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    rsp_rdata_q, rsp_rdata_d;
    logic           rsp_nack_q, rsp_nack_d;
    logic [1:0]     scl_sync_q, sda_sync_q;

    logic scl_s, sda_s, tick, stall, adv, bit_end;
    logic [1:0] byte_nx;

    assign scl_s   = scl_sync_q[1];
    assign sda_s   = sda_sync_q[1];
    assign tick    = (div_q == DIV_LAST);
    assign stall   = (quarter_q == 2'd2) && !scl_s;
    assign adv     = tick && !stall;
    assign bit_end = adv && (quarter_q == 2'd3);
    assign byte_nx = byte_q + 2'd1;

    // Synchronizers idle high to match a pulled-up bus.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_in};
            sda_sync_q <= {sda_sync_q[0], sda_in};
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q     <= S_IDLE;
            quarter_q   <= '0;
            div_q       <= '0;
            bit_q       <= '0;
            byte_q      <= '0;
            sh_q        <= '0;
            rd_q        <= '0;
            nack_q      <= 1'b0;
            rw_q        <= 1'b0;
            dev_q       <= '0;
            reg_q       <= '0;
            len_q       <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_nack_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            quarter_q   <= quarter_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            sh_q        <= sh_d;
            rd_q        <= rd_d;
            nack_q      <= nack_d;
            rw_q        <= rw_d;
            dev_q       <= dev_d;
            reg_q       <= reg_d;
            len_q       <= len_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_nack_q  <= rsp_nack_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        quarter_d   = quarter_q;
        div_d       = div_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        sh_d        = sh_q;
        rd_d        = rd_q;
        nack_d      = nack_q;
        rw_d        = rw_q;
        dev_d       = dev_q;
        reg_d       = reg_q;
        len_d       = len_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_nack_d  = rsp_nack_q;

        if (state_q == S_IDLE || state_q == S_DONE) begin
            state_d   = S_IDLE;
            div_d     = '0;
            quarter_d = '0;
            if (cmd_valid) begin
                state_d = S_START;
                rw_d    = cmd_rw;
                dev_d   = cmd_dev;
                reg_d   = cmd_reg;
                len_d   = cmd_len_m1;
                wdata_d = cmd_wdata;
                bit_d   = '0;
                byte_d  = '0;
                nack_d  = 1'b0;
                rd_d    = '0;
            end
        end else begin
            // Divider parks on its last count while a slave stretches SCL in Q2.
            if (tick) div_d = stall ? div_q : '0;
            else      div_d = div_q + DW'(1);
            if (adv) quarter_d = quarter_q + 2'd1;

            if (bit_end) begin
                case (state_q)
                    S_START: begin
                        state_d = S_ADDR_W;
                        sh_d    = {dev_q, 1'b0};
                    end
                    S_RSTART: begin
                        state_d = S_ADDR_R;
                        sh_d    = {dev_q, 1'b1};
                    end
                    S_STOP: begin
                        state_d     = S_DONE;
                        rsp_nack_d  = nack_q;
                        rsp_rdata_d = (rw_q && !nack_q) ? rd_q : '0;
                    end
                    S_ADDR_W, S_REG, S_WDATA, S_ADDR_R, S_RDATA: begin
                        if (bit_q != 4'd8) begin
                            bit_d = bit_q + 4'd1;
                            sh_d  = {sh_q[6:0], sda_s};
                        end else begin
                            bit_d = '0;
                            if (state_q == S_RDATA) begin
                                rd_d[{byte_q, 3'b000} +: 8] = sh_q;
                                if (byte_q == len_q) state_d = S_STOP;
                                else                 byte_d  = byte_nx;
                            end else if (sda_s) begin
                                nack_d  = 1'b1;
                                state_d = S_STOP;
                            end else begin
                                case (state_q)
                                    S_ADDR_W: begin
                                        state_d = S_REG;
                                        sh_d    = reg_q;
                                    end
                                    S_REG: begin
                                        byte_d = '0;
                                        if (rw_q) begin
                                            state_d = S_RSTART;
                                        end else begin
                                            state_d = S_WDATA;
                                            sh_d    = wdata_q[7:0];
                                        end
                                    end
                                    S_WDATA: begin
                                        if (byte_q == len_q) begin
                                            state_d = S_STOP;
                                        end else begin
                                            byte_d = byte_nx;
                                            sh_d   = wdata_q[{byte_nx, 3'b000} +: 8];
                                        end
                                    end
                                    default: begin
                                        state_d = S_RDATA;
                                        byte_d  = '0;
                                    end
                                endcase
                            end
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state_q)
            S_START: sda_oe = quarter_q[1];
            S_RSTART: begin
                scl_oe = !quarter_q[1];
                sda_oe = (quarter_q == 2'd3);
            end
            S_STOP: begin
                scl_oe = !quarter_q[1];
                sda_oe = (quarter_q != 2'd3);
            end
            S_ADDR_W, S_REG, S_WDATA, S_ADDR_R: begin
                scl_oe = !quarter_q[1];
                sda_oe = (bit_q != 4'd8) ? !sh_q[7] : 1'b0;
            end
            S_RDATA: begin
                scl_oe = !quarter_q[1];
                sda_oe = (bit_q == 4'd8) && (byte_q != len_q);
            end
            default: ;
        endcase
    end

    assign cmd_ready = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy      = !cmd_ready;
    assign rsp_valid = (state_q == S_DONE);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_nack  = rsp_nack_q;

endmodule

// File: tb/tb_i2c_reg_master.sv
// Bench for i2c_reg_master: behavioural I2C slave on a wired-AND bus plus a response scoreboard.
module tb_i2c_reg_master;

    localparam logic [6:0] SLV_ADDR = 7'h50;

    logic        clk = 1'b0;
    logic        resetb;
    logic        cmd_valid, cmd_ready, cmd_rw;
    logic [6:0]  cmd_dev;
    logic [7:0]  cmd_reg;
    logic [1:0]  cmd_len_m1;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_nack, busy;
    logic [31:0] rsp_rdata;
    logic        scl_oe, sda_oe;
    logic        slv_scl_low, slv_sda_low;
    logic        scl_bus, sda_bus;

    always #5 clk = ~clk;

    assign scl_bus = ~scl_oe & ~slv_scl_low;
    assign sda_bus = ~sda_oe & ~slv_sda_low;

    i2c_reg_master #(.CLK_DIV(4)) dut (
        .clk(clk), .resetb(resetb),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_len_m1(cmd_len_m1), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack), .busy(busy),
        .scl_in(scl_bus), .sda_in(sda_bus), .scl_oe(scl_oe), .sda_oe(sda_oe)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        nack;
        int          lat_lo;
        int          lat_hi;
    } rsp_t;

    rsp_t       exp_rsp[$];
    logic [7:0] exp_byte[$];
    logic       exp_mack[$];
    logic [7:0] rmem[4];

    int checks = 0;
    int errors = 0;
    int cyc = 0, acc_cyc = 0, n_acc = 0, rsp_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Cycle counter and accept tracker.
    initial forever begin
        @(posedge clk);
        if (resetb && cmd_valid && cmd_ready) begin
            acc_cyc = cyc;
            n_acc++;
        end
        cyc++;
    end

    // Response monitor.
    initial forever begin
        rsp_t e;
        @(negedge clk);
        if (resetb && rsp_valid) begin
            rsp_cyc = cyc;
            if (exp_rsp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got rdata %0h nack %0b expected no response", rsp_rdata, rsp_nack);
            end else begin
                e = exp_rsp.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_nack", {31'd0, rsp_nack}, {31'd0, e.nack});
                chk_rng("rsp_latency", cyc - acc_cyc, e.lat_lo, e.lat_hi);
                chk("rsp_busy_low", {31'd0, busy}, 32'd0);
                chk("rsp_ready_high", {31'd0, cmd_ready}, 32'd1);
            end
        end
    end

    // Behavioural slave at SLV_ADDR, sampled on negedge so master edges are settled.
    logic       p_scl = 1'b1, p_sda = 1'b1, cur_scl, cur_sda;
    logic       on = 1'b0, first, active, rd_mode, rdone, pend_rd, mack;
    logic       stretch_en = 1'b0;
    logic [7:0] sh, txb, eb;
    int         bitn = -1, nb = 0, ridx = 0, scnt = 0;

    initial begin
        slv_scl_low = 1'b0;
        slv_sda_low = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetb) begin
                slv_scl_low = 1'b0;
                slv_sda_low = 1'b0;
                on = 1'b0;
                scnt = 0;
                p_scl = 1'b1;
                p_sda = 1'b1;
            end else begin
                cur_scl = scl_bus;
                cur_sda = sda_bus;
                if (scnt > 0) begin
                    scnt--;
                    if (scnt == 0) slv_scl_low = 1'b0;
                end
                if (p_scl && cur_scl && p_sda && !cur_sda) begin
                    on = 1'b1; first = 1'b1; active = 1'b0; rd_mode = 1'b0;
                    rdone = 1'b0; bitn = -1; nb = 0; slv_sda_low = 1'b0;
                end else if (p_scl && cur_scl && !p_sda && cur_sda) begin
                    on = 1'b0;
                    slv_sda_low = 1'b0;
                end else if (on && !p_scl && cur_scl) begin
                    if (bitn >= 0 && bitn < 8 && !rd_mode) begin
                        sh = {sh[6:0], cur_sda};
                    end else if (bitn == 8 && rd_mode && !rdone) begin
                        mack = cur_sda;
                        if (exp_mack.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL master_ack: got %0b expected none", mack);
                        end else begin
                            chk("master_ack", {31'd0, mack}, {31'd0, exp_mack.pop_front()});
                        end
                    end
                end else if (on && p_scl && !cur_scl) begin
                    bitn++;
                    if (bitn == 8) begin
                        if (rd_mode) begin
                            slv_sda_low = 1'b0;
                        end else begin
                            if (exp_byte.size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL bus_byte: got %0h expected none", sh);
                            end else begin
                                eb = exp_byte.pop_front();
                                chk("bus_byte", {24'd0, sh}, {24'd0, eb});
                            end
                            if (first) begin
                                active  = (sh[7:1] == SLV_ADDR);
                                pend_rd = sh[0];
                            end
                            slv_sda_low = active;
                            nb++;
                        end
                    end else if (bitn == 9) begin
                        bitn = 0;
                        slv_sda_low = 1'b0;
                        if (first) begin
                            first = 1'b0;
                            if (active && pend_rd) begin
                                rd_mode = 1'b1;
                                ridx = 0;
                                txb = rmem[0];
                                slv_sda_low = ~txb[7];
                            end
                        end else if (rd_mode && !rdone) begin
                            if (mack) begin
                                rdone = 1'b1;
                            end else begin
                                ridx++;
                                txb = rmem[ridx];
                                slv_sda_low = ~txb[7];
                            end
                        end
                    end else if (rd_mode && !rdone && bitn > 0) begin
                        slv_sda_low = ~txb[7-bitn];
                    end
                    if (stretch_en && !rd_mode && nb == 2 && bitn == 2) begin
                        stretch_en = 1'b0;
                        slv_scl_low = 1'b1;
                        scnt = 100;
                    end
                end
                p_scl = cur_scl;
                p_sda = cur_sda;
            end
        end
    end

    // Call at a negedge; drives the command and releases it just after the accepting edge.
    task automatic send(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                        input logic [1:0] lm1, input logic [31:0] wd);
        int n = 0;
        while (!cmd_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got cmd_ready 0 expected 1");
        end
        cmd_valid  = 1'b1;
        cmd_rw     = rw;
        cmd_dev    = dev;
        cmd_reg    = rg;
        cmd_len_m1 = lm1;
        cmd_wdata  = wd;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 3000);
        if (!rsp_valid) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: got no rsp_valid expected a response");
        end
    endtask

    task automatic push_rsp(input logic [31:0] rd, input logic nk, input int lo, input int hi);
        rsp_t e;
        e.rdata = rd; e.nack = nk; e.lat_lo = lo; e.lat_hi = hi;
        exp_rsp.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish by 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        resetb = 1'b0;
        cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_dev = '0; cmd_reg = '0;
        cmd_len_m1 = '0; cmd_wdata = '0;
        rmem[0] = 8'h11; rmem[1] = 8'h22; rmem[2] = 8'h33; rmem[3] = 8'h44;
        repeat (3) @(negedge clk);
        chk("reset_ready", {31'd0, cmd_ready}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_nack", {31'd0, rsp_nack}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_scl_oe", {31'd0, scl_oe}, 32'd0);
        chk("reset_sda_oe", {31'd0, sda_oe}, 32'd0);
        resetb = 1'b1;
        repeat (4) @(negedge clk);

        // Write 2 bytes: 38 bits * 16 clk + 1.
        exp_byte.push_back(8'hA0); exp_byte.push_back(8'h10);
        exp_byte.push_back(8'hEF); exp_byte.push_back(8'hBE);
        push_rsp(32'h0, 1'b0, 609, 609);
        send(1'b0, 7'h50, 8'h10, 2'd1, 32'h0000BEEF);
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        chk("ready_after_accept", {31'd0, cmd_ready}, 32'd0);
        repeat (100) @(negedge clk);
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_dev = 7'h11;
        chk("ready_while_busy", {31'd0, cmd_ready}, 32'd0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_rsp();

        // Read 4 bytes back-to-back: 66 bits.
        exp_byte.push_back(8'hA0); exp_byte.push_back(8'h20); exp_byte.push_back(8'hA1);
        exp_mack.push_back(1'b0); exp_mack.push_back(1'b0);
        exp_mack.push_back(1'b0); exp_mack.push_back(1'b1);
        push_rsp(32'h44332211, 1'b0, 1057, 1057);
        send(1'b1, 7'h50, 8'h20, 2'd3, 32'h0);
        chk("b2b_accept_cycle", acc_cyc, rsp_cyc);
        wait_rsp();

        // Address NACK: START + 9 + STOP = 11 bits.
        repeat (5) @(negedge clk);
        exp_byte.push_back(8'h78);
        push_rsp(32'h0, 1'b1, 177, 177);
        send(1'b0, 7'h3C, 8'h10, 2'd0, 32'h12345678);
        wait_rsp();

        // Clock stretch of 100 clk on the 3rd data bit: 29 bits nominal.
        repeat (5) @(negedge clk);
        stretch_en = 1'b1;
        exp_byte.push_back(8'hA0); exp_byte.push_back(8'h05); exp_byte.push_back(8'hA5);
        push_rsp(32'h0, 1'b0, 465 + 80, 465 + 110);
        send(1'b0, 7'h50, 8'h05, 2'd0, 32'h000000A5);
        wait_rsp();

        // Asynchronous reset in the middle of the register byte.
        repeat (5) @(negedge clk);
        exp_byte.push_back(8'hA0); exp_byte.push_back(8'h20);
        send(1'b1, 7'h50, 8'h20, 2'd3, 32'h0);
        repeat (200) @(negedge clk);
        #2;
        resetb = 1'b0;
        #1;
        chk("midreset_scl_oe", {31'd0, scl_oe}, 32'd0);
        chk("midreset_sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("midreset_ready", {31'd0, cmd_ready}, 32'd1);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        exp_byte.delete();
        exp_mack.delete();
        exp_rsp.delete();
        @(negedge clk);
        resetb = 1'b1;
        repeat (4) @(negedge clk);

        // Recovery: 4-byte write, 56 bits.
        exp_byte.push_back(8'hA0); exp_byte.push_back(8'h33);
        exp_byte.push_back(8'h01); exp_byte.push_back(8'h02);
        exp_byte.push_back(8'h03); exp_byte.push_back(8'h04);
        push_rsp(32'h0, 1'b0, 897, 897);
        send(1'b0, 7'h50, 8'h33, 2'd3, 32'h04030201);
        wait_rsp();
        repeat (5) @(negedge clk);

        chk("accept_count", n_acc, 6);
        chk("rsp_queue_empty", exp_rsp.size(), 0);
        chk("byte_queue_empty", exp_byte.size(), 0);
        chk("mack_queue_empty", exp_mack.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
